// File: rtl/sym_err_counter.sv
// sym_err_counter: finds the tx->rx symbol delay by search, then counts symbols and symbol errors.
// Ports: clk, reset (async, high); clk_en symbol enable; sym_tx/sym_rx symbol streams;
// clr_counts sync clear of counters; locked, delay_out, sym_count, err_count, err_flag status.
module sym_err_counter #(
  parameter int unsigned SYM_W       = 2,
  parameter int unsigned MAX_DELAY   = 15,
  parameter int unsigned DLY_W       = 4,
  parameter int unsigned SEARCH_LEN  = 64,
  parameter int unsigned LOCK_THRESH = 4,
  parameter int unsigned UNLOCK_WIN  = 64,
  parameter int unsigned UNLOCK_ERRS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic [SYM_W-1:0] sym_tx,
  input  logic [SYM_W-1:0] sym_rx,
  input  logic             clr_counts,
  output logic             locked,
  output logic [DLY_W-1:0] delay_out,
  output logic [31:0]      sym_count,
  output logic [31:0]      err_count,
  output logic             err_flag
);
  localparam int unsigned WMAX  = (SEARCH_LEN > UNLOCK_WIN) ? SEARCH_LEN : UNLOCK_WIN;
  localparam int unsigned WIN_W = $clog2(WMAX + 1);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t            state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d, dly_inc;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d, win_err_q, win_err_d, tot;
  logic [31:0]       sym_cnt_q, sym_cnt_d, err_cnt_q, err_cnt_d;
  logic              flag_q, flag_d, mis;
  logic [SYM_W-1:0]  ref_sym;
  logic [SYM_W-1:0]  hist_q [MAX_DELAY];
  // dly_q is the candidate while searching and the locked delay afterwards
  assign ref_sym = (dly_q == '0) ? sym_tx : hist_q[dly_q - 1'b1];
  assign mis     = (sym_rx != ref_sym);
  assign tot     = win_err_q + WIN_W'(mis);
  assign dly_inc = (dly_q == DLY_W'(MAX_DELAY)) ? '0 : dly_q + 1'b1;
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    sym_cnt_d = sym_cnt_q;
    err_cnt_d = err_cnt_q;
    flag_d    = flag_q;
    if (clk_en) begin
      if (state_q == SEARCH) begin
        win_cnt_d = (win_cnt_q == WIN_W'(SEARCH_LEN - 1)) ? '0 : win_cnt_q + 1'b1;
        win_err_d = (win_cnt_q == WIN_W'(SEARCH_LEN - 1)) ? '0 : tot;
        if (win_cnt_q == WIN_W'(SEARCH_LEN - 1)) begin
          state_d = (tot <= WIN_W'(LOCK_THRESH)) ? LOCKED : SEARCH;
          dly_d   = (tot <= WIN_W'(LOCK_THRESH)) ? dly_q : dly_inc;
        end
      end else begin
        sym_cnt_d = (sym_cnt_q == '1) ? sym_cnt_q : sym_cnt_q + 1'b1;
        err_cnt_d = (mis && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
        flag_d    = mis;
        win_cnt_d = (win_cnt_q == WIN_W'(UNLOCK_WIN - 1)) ? '0 : win_cnt_q + 1'b1;
        win_err_d = (win_cnt_q == WIN_W'(UNLOCK_WIN - 1)) ? '0 : tot;
        // too many errors in this window: drop lock and resume search past the old delay
        if (tot >= WIN_W'(UNLOCK_ERRS)) begin
          state_d   = SEARCH;
          flag_d    = 1'b0;
          dly_d     = dly_inc;
          win_cnt_d = '0;
          win_err_d = '0;
        end
      end
    end
    if (clr_counts) begin
      sym_cnt_d = '0;
      err_cnt_d = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      dly_q     <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      sym_cnt_q <= '0;
      err_cnt_q <= '0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      sym_cnt_q <= sym_cnt_d;
      err_cnt_q <= err_cnt_d;
      flag_q    <= flag_d;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(MAX_DELAY); k++) hist_q[k] <= '0;
    end else if (clk_en) begin
      hist_q[0] <= sym_tx;
      for (int k = 1; k < int'(MAX_DELAY); k++) hist_q[k] <= hist_q[k-1];
    end
  end
  assign locked    = (state_q == LOCKED);
  assign delay_out = dly_q;
  assign sym_count = sym_cnt_q;
  assign err_count = err_cnt_q;
  assign err_flag  = flag_q;
endmodule
